// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants shared by the sync generator, the RGB stage and the sprite logic.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CNT_W    = 11;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered display and sync-active flags.
// Flags are loaded from the next count so they always line up with the count they describe.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int CNT_W  = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             display,
    output logic             sync_active
);

    localparam int               TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] next_count;

    // wrap flags the terminal count, so the next enabled step returns to zero.
    always_comb begin
        wrap       = (count == LAST);
        next_count = wrap ? '0 : count + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= LAST;
            display     <= 1'b0;
            sync_active <= 1'b0;
        end else if (enable) begin
            count       <= next_count;
            display     <= (next_count < ACT_END);
            sync_active <= (next_count >= SYNC_START) && (next_count < SYNC_END);
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing: pixel-rate divider, H/V axis counters, sync/display enables and line/frame strobes.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic             Pixel_Tick,
    output logic             H_Sync,
    output logic             V_Sync,
    output logic             H_Display,
    output logic             V_Display,
    output logic [CNT_W-1:0] Pixel_X,
    output logic [CNT_W-1:0] Pixel_Y,
    output logic             Line_Start,
    output logic             Frame_Start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync_active;
    logic             v_sync_active;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Strobes are registered alongside the counters so they share the same update edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Pixel_Tick  <= 1'b0;
            Line_Start  <= 1'b0;
            Frame_Start <= 1'b0;
        end else begin
            Pixel_Tick  <= tick;
            Line_Start  <= tick && h_wrap;
            Frame_Start <= tick && h_wrap && v_wrap;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk         (clk),
        .reset       (reset),
        .enable      (tick),
        .count       (Pixel_X),
        .wrap        (h_wrap),
        .display     (H_Display),
        .sync_active (h_sync_active)
    );

    // The vertical axis only steps on the pixel where the line wraps.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk         (clk),
        .reset       (reset),
        .enable      (tick && h_wrap),
        .count       (Pixel_Y),
        .wrap        (v_wrap),
        .display     (V_Display),
        .sync_active (v_sync_active)
    );

    assign H_Sync = SYNC_POL ? h_sync_active : ~h_sync_active;
    assign V_Sync = SYNC_POL ? v_sync_active : ~v_sync_active;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: full 640x480 instance (CLK_DIV=2, active-low syncs) and a tiny
// raster instance (CLK_DIV=1, active-high syncs), both checked every clock against an arithmetic model.
module tb_vga_sync_generator;

    localparam int CNT_W = 11;

    // Instance A: standard timing.
    localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
    localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
    localparam int A_DIV = 2;
    localparam bit A_POL = 1'b0;
    // Instance B: small raster so whole frames fit in a short run (15 x 9).
    localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HBP = 2;
    localparam int B_VA = 5, B_VFP = 1, B_VS = 2, B_VBP = 1;
    localparam int B_DIV = 1;
    localparam bit B_POL = 1'b1;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        tick;
        logic        hs;
        logic        vs;
        logic        hd;
        logic        vd;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    longint cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic             a_tick, a_hs, a_vs, a_hd, a_vd, a_ls, a_fs;
    logic [CNT_W-1:0] a_x, a_y;
    logic             b_tick, b_hs, b_vs, b_hd, b_vd, b_ls, b_fs;
    logic [CNT_W-1:0] b_x, b_y;

    always #5 clk = ~clk;

    vga_sync_generator #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .CLK_DIV(A_DIV), .SYNC_POL(A_POL), .CNT_W(CNT_W)
    ) dut_a (
        .clk(clk), .reset(reset), .Pixel_Tick(a_tick), .H_Sync(a_hs), .V_Sync(a_vs),
        .H_Display(a_hd), .V_Display(a_vd), .Pixel_X(a_x), .Pixel_Y(a_y),
        .Line_Start(a_ls), .Frame_Start(a_fs)
    );

    vga_sync_generator #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .CLK_DIV(B_DIV), .SYNC_POL(B_POL), .CNT_W(CNT_W)
    ) dut_b (
        .clk(clk), .reset(reset), .Pixel_Tick(b_tick), .H_Sync(b_hs), .V_Sync(b_vs),
        .H_Display(b_hd), .V_Display(b_vd), .Pixel_X(b_x), .Pixel_Y(b_y),
        .Line_Start(b_ls), .Frame_Start(b_fs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs after n clock edges out of reset: pixel count p = n / div, and pixel p sits at
    // raster position p-1 in row-major order; p = 0 means still at the reset position.
    function automatic exp_t model(input int ha, input int hfp, input int hsy, input int hbp,
                                   input int va, input int vfp, input int vsy, input int vbp,
                                   input int div, input bit pol, input longint n);
        exp_t   e;
        longint ht, vt, p, k, x, y;
        bit     hs_act, vs_act;
        ht = ha + hfp + hsy + hbp;
        vt = va + vfp + vsy + vbp;
        p  = n / div;
        if (p == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            k = p - 1;
            x = k % ht;
            y = (k / ht) % vt;
        end
        hs_act = (p > 0) && (x >= ha + hfp) && (x < ha + hfp + hsy);
        vs_act = (p > 0) && (y >= va + vfp) && (y < va + vfp + vsy);
        e.x    = 32'(x);
        e.y    = 32'(y);
        e.tick = (n > 0) && (n % div == 0);
        e.hs   = pol ? hs_act : !hs_act;
        e.vs   = pol ? vs_act : !vs_act;
        e.hd   = (p > 0) && (x < ha);
        e.vd   = (p > 0) && (y < va);
        e.ls   = e.tick && (x == 0);
        e.fs   = e.ls && (y == 0);
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Every-cycle scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_DIV, A_POL, cyc);
        eb = model(B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_DIV, B_POL, cyc);
        check("a_pixel_x",     32'(a_x),    ea.x);
        check("a_pixel_y",     32'(a_y),    ea.y);
        check("a_pixel_tick",  32'(a_tick), 32'(ea.tick));
        check("a_h_sync",      32'(a_hs),   32'(ea.hs));
        check("a_v_sync",      32'(a_vs),   32'(ea.vs));
        check("a_h_display",   32'(a_hd),   32'(ea.hd));
        check("a_v_display",   32'(a_vd),   32'(ea.vd));
        check("a_line_start",  32'(a_ls),   32'(ea.ls));
        check("a_frame_start", 32'(a_fs),   32'(ea.fs));
        check("b_pixel_x",     32'(b_x),    eb.x);
        check("b_pixel_y",     32'(b_y),    eb.y);
        check("b_pixel_tick",  32'(b_tick), 32'(eb.tick));
        check("b_h_sync",      32'(b_hs),   32'(eb.hs));
        check("b_v_sync",      32'(b_vs),   32'(eb.vs));
        check("b_h_display",   32'(b_hd),   32'(eb.hd));
        check("b_v_display",   32'(b_vd),   32'(eb.vd));
        check("b_line_start",  32'(b_ls),   32'(eb.ls));
        check("b_frame_start", 32'(b_fs),   32'(eb.fs));
    end

    // Literal expectations for the first two edges after reset release.
    task automatic first_tick_checks(input string tag);
        @(posedge clk); #1;
        check({tag, "_a_no_tick_clk1"},   32'(a_tick), 32'd0);
        check({tag, "_b_tick_clk1"},      32'(b_tick), 32'd1);
        check({tag, "_b_frame_clk1"},     32'(b_fs),   32'd1);
        @(posedge clk); #1;
        check({tag, "_a_tick_clk2"},      32'(a_tick), 32'd1);
        check({tag, "_a_frame_start"},    32'(a_fs),   32'd1);
        check({tag, "_a_line_start"},     32'(a_ls),   32'd1);
        check({tag, "_a_x0"},             32'(a_x),    32'd0);
        check({tag, "_a_y0"},             32'(a_y),    32'd0);
        check({tag, "_a_h_display"},      32'(a_hd),   32'd1);
        check({tag, "_a_v_display"},      32'(a_vd),   32'd1);
    endtask

    task automatic release_reset();
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin
        int  lines, hs_low, ticks_low, vs_high, b_lines, clks;
        bit  found;

        // Reset state, literal.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_x",          32'(a_x),  32'd799);
        check("rst_a_y",          32'(a_y),  32'd524);
        check("rst_a_h_sync",     32'(a_hs), 32'd1);
        check("rst_b_h_sync",     32'(b_hs), 32'd0);
        check("rst_a_strobes",    32'({a_tick, a_ls, a_fs}), 32'd0);
        release_reset();
        first_tick_checks("start");

        // One standard line: period and H_Sync low time in clocks.
        clks = 0; hs_low = 0; found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            clks++;
            if (a_hs == 1'b0) hs_low++;
            if (a_ls) found = 1;
        end
        check("a_line_found",     32'(found),  32'd1);
        check("a_line_period",    32'(clks),   32'd1600);
        check("a_hsync_low_clks", 32'(hs_low), 32'd192);

        // Small raster: frame period, V_Sync time, lines per frame, continuous tick.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (b_fs) found = 1;
        end
        check("b_frame_found", 32'(found), 32'd1);
        clks = 0; vs_high = 0; b_lines = 0; ticks_low = 0; found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            clks++;
            if (b_vs) vs_high++;
            if (b_ls) b_lines++;
            if (!b_tick) ticks_low++;
            if (b_fs) found = 1;
        end
        check("b_frame_period",   32'(clks),      32'd135);
        check("b_vsync_clks",     32'(vs_high),   32'd30);
        check("b_lines_in_frame", 32'(b_lines),   32'd9);
        check("b_tick_low_clks",  32'(ticks_low), 32'd0);

        // Reset in the middle of horizontal sync.
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk); #1;
            if (a_x == CNT_W'(700)) found = 1;
        end
        check("a_x700_found",       32'(found), 32'd1);
        check("a_hsync_active_700", 32'(a_hs),  32'd0);
        #1 reset = 1'b1;
        #1;
        check("midrst_a_h_sync",  32'(a_hs), 32'd1);
        check("midrst_a_x",       32'(a_x),  32'd799);
        check("midrst_a_strobes", 32'({a_tick, a_ls, a_fs, b_tick, b_ls, b_fs}), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        first_tick_checks("restart");

        // Randomized reset pulses; the scoreboard covers every cycle in between.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(6000, 50)) @(posedge clk);
            #($urandom_range(4, 1));
            reset = 1'b1;
            repeat ($urandom_range(4, 1)) @(posedge clk);
            release_reset();
        end
        repeat (3500) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
